dmem_responder: RTL and testbench

//   Memory-side responder for pipeline data accesses: the slave end of the MEM-stage load/store interface.
//   - Accepts one request at a time via valid/ready: address, read_write, access_size, store data.
//   - Services the request against a word-wide backing array after a fixed access latency.
//   - Returns zero-extended load data, or an error flag, via valid/ready.
//   - Array has no byte enables, so sub-word stores are read-modify-write.

---
 rtl/dmem_responder.sv | 254 +++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for pipeline data accesses (slave end of the
//   MEM-stage load/store interface). One request is accepted at a time.
//   It is serviced against a word-wide backing array after a fixed latency,
//   and the response is held until the requester takes it. The array has no
//   byte enables, so byte and half stores are done as read-modify-write.
//
// Ports
//   clock      in   1   rising-edge clock
//   reset      in   1   synchronous, active-high
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept a request
//   req_addr   in   32  byte address
//   req_rw     in   1   0 = read, 1 = write
//   req_size   in   2   0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_wdata  in   32  store data, right-justified
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   requester consumes the response
//   rsp_rdata  out  32  zero-extended load data; 0 for writes and errors
//   rsp_err    out  1   request rejected (misaligned, illegal size, out of range)
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_rw,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_MERGE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Replace the addressed byte/half lane of old_word with right-justified data.
    function automatic logic [31:0] merge_lane(input logic [31:0] old_word,
                                               input logic [31:0] data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [31:0] w;
        w = old_word;
        case (size)
            2'd0: begin
                case (lane)
                    2'd0:    w[7:0]   = data[7:0];
                    2'd1:    w[15:8]  = data[7:0];
                    2'd2:    w[23:16] = data[7:0];
                    2'd3:    w[31:24] = data[7:0];
                    default: w = old_word;
                endcase
            end
            2'd1: begin
                if (lane[1]) w[31:16] = data[15:0];
                else         w[15:0]  = data[15:0];
            end
            default: w = data;
        endcase
        return w;
    endfunction

    // Pick the addressed byte/half lane out of a word and zero-extend it.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane);
        logic [31:0] r;
        case (size)
            2'd0: begin
                case (lane)
                    2'd0:    r = {24'h00_0000, word[7:0]};
                    2'd1:    r = {24'h00_0000, word[15:8]};
                    2'd2:    r = {24'h00_0000, word[23:16]};
                    2'd3:    r = {24'h00_0000, word[31:24]};
                    default: r = 32'h0000_0000;
                endcase
            end
            2'd1: begin
                if (lane[1]) r = {16'h0000, word[31:16]};
                else         r = {16'h0000, word[15:0]};
            end
            default: r = word;
        endcase
        return r;
    endfunction

    logic [31:0]      off_s;
    logic [1:0]       lane_s;
    logic [IDX_W-1:0] idx_s;
    logic             req_err_s;

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic [1:0]       lane_r;
    logic             rw_r;
    logic [1:0]       size_r;
    logic [31:0]      wdata_r;
    logic [31:0]      old_word_r;
    logic             req_ready_r;
    logic             rsp_valid_r;
    logic [31:0]      rsp_rdata_r;
    logic             rsp_err_r;

    logic [31:0]      mem_r [DEPTH_WORDS];
    logic [31:0]      mem_rdata_s;
    logic             mem_we_s;
    logic [31:0]      mem_wdata_s;

    assign req_ready   = req_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_err     = rsp_err_r;
    assign mem_rdata_s = mem_r[idx_r];

    // Decode the incoming address into word index / lane and classify errors.
    always_comb begin
        off_s     = req_addr - BASE_ADDR;
        lane_s    = off_s[1:0];
        idx_s     = off_s[IDX_W+1:2];
        req_err_s = 1'b0;
        if ((req_addr < BASE_ADDR) || (off_s >= SPAN_BYTES)) begin
            req_err_s = 1'b1;
        end else begin
            case (req_size)
                2'd0:    req_err_s = 1'b0;
                2'd1:    req_err_s = lane_s[0];
                2'd2:    req_err_s = (lane_s != 2'd0);
                default: req_err_s = 1'b1;
            endcase
        end
    end

    // Array write port: word stores commit leaving WAIT, sub-word leaving MERGE.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_wdata_s = wdata_r;
        if (reset) begin
            mem_we_s = 1'b0;
        end else if ((state_r == ST_WAIT) && (cnt_r == CNT_ZERO) && rw_r && (size_r == 2'd2)) begin
            mem_we_s = 1'b1;
        end else if (state_r == ST_MERGE) begin
            mem_we_s    = 1'b1;
            mem_wdata_s = merge_lane(old_word_r, wdata_r, size_r, lane_r);
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Backing array; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) mem_r[idx_r] <= mem_wdata_s;
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            idx_r       <= {IDX_W{1'b0}};
            lane_r      <= 2'd0;
            rw_r        <= 1'b0;
            size_r      <= 2'd0;
            wdata_r     <= 32'h0000_0000;
            old_word_r  <= 32'h0000_0000;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        idx_r       <= idx_s;
                        lane_r      <= lane_s;
                        rw_r        <= req_rw;
                        size_r      <= req_size;
                        wdata_r     <= req_wdata;
                        req_ready_r <= 1'b0;
                        if (req_err_s) begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_rdata_r <= 32'h0000_0000;
                            rsp_err_r   <= 1'b1;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= CNT_LOAD;
                        end
                    end else begin
                        // Ready rises one cycle after reset and stays up while idle.
                        req_ready_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (!rw_r) begin
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= extract_load(mem_rdata_s, size_r, lane_r);
                        rsp_err_r   <= 1'b0;
                    end else if (size_r == 2'd2) begin
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= 32'h0000_0000;
                        rsp_err_r   <= 1'b0;
                    end else begin
                        old_word_r <= mem_rdata_s;
                        state_r    <= ST_MERGE;
                    end
                end
                ST_MERGE: begin
                    state_r     <= ST_RESP;
                    rsp_valid_r <= 1'b1;
                    rsp_rdata_r <= 32'h0000_0000;
                    rsp_err_r   <= 1'b0;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        rsp_rdata_r <= 32'h0000_0000;
                        rsp_err_r   <= 1'b0;
                        req_ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= 32'h0000_0000;
                    rsp_err_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Table-driven directed vectors, hand-written multi-cycle sequences
//   (backpressure, reset in WAIT / MERGE / RESP) and a randomized phase
//   checked against an arithmetic reference model of the memory.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_rw;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int vec_count  = 0;
    int miscompares = 0;

    logic [31:0] ref_mem [int];

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .LATENCY    (LAT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_rw   (req_rw),
        .req_size (req_size),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic [31:0] addr, input logic rw, input logic [1:0] size,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err, input int exp_lat);
        vec_t v;
        v.addr = addr; v.rw = rw; v.size = size; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Reference model: plain byte-offset arithmetic over a word dictionary.
    task automatic ref_access(input logic [31:0] addr, input logic rw, input logic [1:0] size,
                              input logic [31:0] wdata, output logic [31:0] rdata,
                              output logic err, output int lat);
        longint      off;
        int          nbytes;
        int          w;
        int          sh;
        logic [31:0] mask;
        off    = longint'(addr) - longint'(BASE);
        nbytes = 1 << size;
        err    = (size == 2'd3) || (off < 0) || (off >= DEPTH * 4) || ((off % nbytes) != 0);
        rdata  = 32'h0;
        if (err)                   lat = 1;
        else if (rw && nbytes < 4) lat = LAT + 2;
        else                       lat = LAT + 1;
        if (!err) begin
            w    = int'(off / 4);
            sh   = int'(off % 4) * 8;
            mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
            if (rw) ref_mem[w] = (ref_mem[w] & ~(mask << sh)) | ((wdata & mask) << sh);
            else    rdata = (ref_mem[w] >> sh) & mask;
        end
    endtask

    // Wait for ready, present a request, return at the falling edge of cycle 1.
    task automatic issue(input logic [31:0] addr, input logic rw, input logic [1:0] size,
                         input logic [31:0] wdata, output logic ok);
        int waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(negedge clock);
            waitc++;
        end
        ok = req_ready;
        if (!ok) begin
            chk("req_ready_timeout", 0, 32'(req_ready), 32'h1);
        end else begin
            req_valid = 1'b1; req_addr = addr; req_rw = rw; req_size = size; req_wdata = wdata;
            @(posedge clock);
            @(negedge clock);
            req_valid = 1'b0;
            req_addr  = $urandom();
            req_wdata = $urandom();
        end
    endtask

    task automatic run_txn(input logic [31:0] addr, input logic rw, input logic [1:0] size,
                           input logic [31:0] wdata, input int ready_delay,
                           output logic [31:0] rdata, output logic err, output int lat);
        logic ok;
        rdata = 32'h0; err = 1'b0; lat = -1;
        issue(addr, rw, size, wdata, ok);
        if (ok) begin
            lat = 1;
            while (!rsp_valid && lat < 30) begin
                @(negedge clock);
                lat++;
            end
            if (!rsp_valid) begin
                chk("rsp_valid_timeout", 0, 32'(rsp_valid), 32'h1);
                lat = -1;
            end else begin
                rdata = rsp_rdata;
                err   = rsp_err;
                repeat (ready_delay) @(negedge clock);
                rsp_ready = 1'b1;
                @(posedge clock);
                @(negedge clock);
                rsp_ready = 1'b0;
            end
        end
    endtask

    task automatic check_reset_outputs(input int tag);
        chk("rst_req_ready", tag, 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", tag, 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", tag, rsp_rdata, 32'h0);
        chk("rst_rsp_err",   tag, 32'(rsp_err), 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;
        logic        ok;
        logic [31:0] e_rd;
        logic        e_er;
        int          e_lt;
        int          idxs[12];

        reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_rw = 1'b0;
        req_size = 2'd0; req_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_outputs(0);
        reset = 1'b0;

        // Directed table: functional checks and boundary conditions.
        vecs.push_back(mk(BASE + 32'h10, 1'b1, 2'd2, 32'hDEAD_BEEF, 32'h0,         1'b0, 3));
        vecs.push_back(mk(BASE + 32'h10, 1'b0, 2'd2, 32'h0,         32'hDEAD_BEEF, 1'b0, 3));
        vecs.push_back(mk(BASE + 32'h11, 1'b1, 2'd0, 32'h5555_55AA, 32'h0,         1'b0, 4));
        vecs.push_back(mk(BASE + 32'h10, 1'b0, 2'd2, 32'h0,         32'hDEAD_AAEF, 1'b0, 3));
        vecs.push_back(mk(BASE + 32'h13, 1'b0, 2'd0, 32'h0,         32'h0000_00DE, 1'b0, 3));
        vecs.push_back(mk(BASE + 32'h12, 1'b0, 2'd1, 32'h0,         32'h0000_DEAD, 1'b0, 3));
        vecs.push_back(mk(BASE + 32'h10, 1'b0, 2'd1, 32'h0,         32'h0000_AAEF, 1'b0, 3));
        vecs.push_back(mk(BASE + 32'h11, 1'b0, 2'd0, 32'h0,         32'h0000_00AA, 1'b0, 3));
        vecs.push_back(mk(BASE + 32'h2,  1'b0, 2'd2, 32'h0,         32'h0,         1'b1, 1));
        vecs.push_back(mk(BASE + 32'h11, 1'b1, 2'd1, 32'h1234_5678, 32'h0,         1'b1, 1));
        vecs.push_back(mk(BASE + 32'h10, 1'b0, 2'd3, 32'h0,         32'h0,         1'b1, 1));
        vecs.push_back(mk(BASE + 32'h10, 1'b1, 2'd3, 32'h0BAD_0BAD, 32'h0,         1'b1, 1));
        vecs.push_back(mk(BASE + 32'h10, 1'b0, 2'd2, 32'h0,         32'hDEAD_AAEF, 1'b0, 3));
        vecs.push_back(mk(BASE - 32'h4,  1'b0, 2'd2, 32'h0,         32'h0,         1'b1, 1));
        vecs.push_back(mk(BASE + 32'h1000, 1'b0, 2'd2, 32'h0,       32'h0,         1'b1, 1));
        vecs.push_back(mk(BASE + 32'hFFC, 1'b1, 2'd2, 32'h0BAD_F00D, 32'h0,        1'b0, 3));
        vecs.push_back(mk(BASE + 32'hFFC, 1'b0, 2'd2, 32'h0,        32'h0BAD_F00D, 1'b0, 3));
        vecs.push_back(mk(BASE + 32'hFFE, 1'b1, 2'd1, 32'h1111_CAFE, 32'h0,        1'b0, 4));
        vecs.push_back(mk(BASE + 32'hFFC, 1'b0, 2'd2, 32'h0,        32'hCAFE_F00D, 1'b0, 3));
        vecs.push_back(mk(BASE + 32'hFFF, 1'b0, 2'd0, 32'h0,        32'h0000_00CA, 1'b0, 3));
        vecs.push_back(mk(BASE + 32'hFFD, 1'b0, 2'd1, 32'h0,        32'h0,         1'b1, 1));

        foreach (vecs[i]) begin
            run_txn(vecs[i].addr, vecs[i].rw, vecs[i].size, vecs[i].wdata, i % 3, rd, er, lt);
            chk("vec_rdata", i, rd, vecs[i].exp_rdata);
            chk("vec_err",   i, 32'(er), 32'(vecs[i].exp_err));
            chk("vec_lat",   i, 32'(lt), 32'(vecs[i].exp_lat));
        end

        // Backpressure: response held, extra request ignored, ready returns after handshake.
        issue(BASE + 32'h10, 1'b0, 2'd2, 32'h0, ok);
        req_valid = 1'b1; req_addr = BASE + 32'h14; req_rw = 1'b1; req_size = 2'd2; req_wdata = 32'h7777_7777;
        lt = 1;
        while (!rsp_valid && lt < 30) begin
            @(negedge clock);
            lt++;
        end
        chk("bp_lat", 0, 32'(lt), 32'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("bp_valid", k, 32'(rsp_valid), 32'h1);
            chk("bp_rdata", k, rsp_rdata, 32'hDEAD_AAEF);
            chk("bp_ready", k, 32'(req_ready), 32'h0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("bp_ready_after", 0, 32'(req_ready), 32'h1);
        chk("bp_valid_after", 0, 32'(rsp_valid), 32'h0);

        // Reset in WAIT of a word write: nothing committed.
        issue(BASE + 32'h10, 1'b1, 2'd2, 32'h1234_5678, ok);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_reset_outputs(1);
        reset = 1'b0;
        run_txn(BASE + 32'h10, 1'b0, 2'd2, 32'h0, 0, rd, er, lt);
        chk("rst_wait_rdata", 0, rd, 32'hDEAD_AAEF);
        chk("rst_wait_lat",   0, 32'(lt), 32'd3);

        // Reset in MERGE of a byte write: nothing committed.
        issue(BASE + 32'h10, 1'b1, 2'd0, 32'h0000_0055, ok);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_reset_outputs(2);
        reset = 1'b0;
        run_txn(BASE + 32'h10, 1'b0, 2'd2, 32'h0, 0, rd, er, lt);
        chk("rst_merge_rdata", 0, rd, 32'hDEAD_AAEF);

        // Reset in RESP: pending response discarded.
        issue(BASE + 32'h10, 1'b0, 2'd2, 32'h0, ok);
        repeat (2) @(negedge clock);
        chk("resp_pending", 0, 32'(rsp_valid), 32'h1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_reset_outputs(3);
        reset = 1'b0;

        // Randomized phase: seed a set of words, then random accesses vs model.
        for (int k = 0; k < 8; k++) idxs[k] = k;
        for (int k = 0; k < 4; k++) idxs[8 + k] = DEPTH - 4 + k;
        foreach (idxs[k]) begin
            logic [31:0] a;
            logic [31:0] d;
            a = BASE + 32'(idxs[k] * 4);
            d = $urandom();
            ref_mem[idxs[k]] = 32'h0;
            ref_access(a, 1'b1, 2'd2, d, e_rd, e_er, e_lt);
            run_txn(a, 1'b1, 2'd2, d, 0, rd, er, lt);
            chk("seed_err", k, 32'(er), 32'(e_er));
        end
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic        rw;
            logic [1:0]  sz;
            rw = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            d  = $urandom();
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) a = BASE - 32'($urandom_range(1, 16));
                else                           a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 15));
            end else begin
                a = BASE + 32'(idxs[$urandom_range(0, 11)] * 4) + 32'($urandom_range(0, 3));
            end
            ref_access(a, rw, sz, d, e_rd, e_er, e_lt);
            run_txn(a, rw, sz, d, $urandom_range(0, 2), rd, er, lt);
            chk("rnd_rdata", n, rd, e_rd);
            chk("rnd_err",   n, 32'(er), 32'(e_er));
            chk("rnd_lat",   n, 32'(lt), 32'(e_lt));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
